// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter.
//   - default address/data widths
//   - FSM state and owner encodings
//   - read-return tag carried through the latency pipe
//   - saturating increment helper for the starvation counter
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned STARVE_W   = 4;
   localparam int unsigned STAT_W     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      IO_ACC  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_IO  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

   // Increment that stops at lim.
   function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                      input logic [STARVE_W-1:0] lim);
      return (cnt == lim) ? cnt : cnt + STARVE_W'(1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU requester, IO requester and memory port bundle.
//   slave  : arbiter view (takes requests and memRdata, drives acks/returns/memory)
//   master : environment view (requesters plus memory model)
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              cpuReq;
   logic              cpuWe;
   logic [ADDR_W-1:0] cpuAddr;
   logic [DATA_W-1:0] cpuWdata;
   logic              cpuAck;
   logic              cpuRvalid;
   logic [DATA_W-1:0] cpuRdata;

   logic              ioReq;
   logic              ioWe;
   logic [ADDR_W-1:0] ioAddr;
   logic [DATA_W-1:0] ioWdata;
   logic              ioAck;
   logic              ioRvalid;
   logic [DATA_W-1:0] ioRdata;

   logic              memEn;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic [DATA_W-1:0] memRdata;

   modport slave (
      input  cpuReq, cpuWe, cpuAddr, cpuWdata,
      input  ioReq, ioWe, ioAddr, ioWdata,
      input  memRdata,
      output cpuAck, cpuRvalid, cpuRdata,
      output ioAck, ioRvalid, ioRdata,
      output memEn, memWe, memAddr, memWdata
   );

   modport master (
      output cpuReq, cpuWe, cpuAddr, cpuWdata,
      output ioReq, ioWe, ioAddr, ioWdata,
      output memRdata,
      input  cpuAck, cpuRvalid, cpuRdata,
      input  ioAck, ioRvalid, ioRdata,
      input  memEn, memWe, memAddr, memWdata
   );

endinterface

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// mem_rd_return_pipe: delays the {valid, owner} tag of each issued read by
// MEM_LATENCY cycles and steers memRdata to the owning requester.
//   clock, reset       : clock, async active-low reset
//   issue_i, owner_i   : read issued this cycle and its owner
//   mem_rdata_i        : memory read data
//   cpu/io_rvalid_o    : one-cycle return pulse per owner
//   cpu/io_rdata_o     : read data, held between returns
module mem_rd_return_pipe
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_i,
   input  owner_e            owner_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              io_rvalid_o,
   output logic [DATA_W-1:0] io_rdata_o
);

   rd_tag_t           tag_q [MEM_LATENCY];
   rd_tag_t           tail;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] io_rdata_q;

   // Tag shift register; reset discards reads still in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{valid: issue_i, owner: owner_i};
         for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tail         = tag_q[MEM_LATENCY-1];
   assign cpu_rvalid_o = tail.valid && (tail.owner == OWN_CPU);
   assign io_rvalid_o  = tail.valid && (tail.owner == OWN_IO);

   // Hold the last returned word per owner.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cpu_rdata_q <= '0;
         io_rdata_q  <= '0;
      end else begin
         if (cpu_rvalid_o) cpu_rdata_q <= mem_rdata_i;
         if (io_rvalid_o)  io_rdata_q  <= mem_rdata_i;
      end
   end

   // The memory word is only present during the return cycle, so it bypasses
   // the hold register then and is latched for the following cycles.
   assign cpu_rdata_o = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
   assign io_rdata_o  = io_rvalid_o  ? mem_rdata_i : io_rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a CPU and an IO requester.
//   clock, reset : clock, async active-low reset
//   bus          : requester handshakes, read returns and memory port
// Optional MEM_ARB_STATS_EN adds cpuGrantCnt, ioGrantCnt, conflictCnt
// (saturating grant/conflict counters).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned CPU_PRIORITY = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                clock,
   input logic                reset,
   mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]  cpuGrantCnt,
   output logic [STAT_W-1:0]  ioGrantCnt,
   output logic [STAT_W-1:0]  conflictCnt
`endif
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_e          state_q, state_d;
   owner_e              last_q, last_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                io_ack_q, io_ack_d;
   logic                both_req;
   logic                io_win;

   // Winner when at least one requester is active.
   assign both_req = bus.cpuReq & bus.ioReq;
   assign io_win   = !both_req             ? bus.ioReq :
                     (CPU_PRIORITY != 0)   ? (starve_q == STARVE_MAX) :
                                             (last_q == OWN_CPU);

   // Next state and next registered memory/ack outputs.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      starve_d    = starve_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      cpu_ack_d   = 1'b0;
      io_ack_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cpuReq || bus.ioReq) begin
               mem_en_d = 1'b1;
               if (io_win) begin
                  state_d     = IO_ACC;
                  last_d      = OWN_IO;
                  mem_we_d    = bus.ioWe;
                  mem_addr_d  = bus.ioAddr;
                  mem_wdata_d = bus.ioWdata;
                  io_ack_d    = 1'b1;
               end else begin
                  state_d     = CPU_ACC;
                  last_d      = OWN_CPU;
                  mem_we_d    = bus.cpuWe;
                  mem_addr_d  = bus.cpuAddr;
                  mem_wdata_d = bus.cpuWdata;
                  cpu_ack_d   = 1'b1;
               end
            end
            starve_d = (!bus.ioReq || io_win) ? '0 : starve_inc(starve_q, STARVE_MAX);
         end
         CPU_ACC, IO_ACC: state_d = IDLE;
         default:         state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= OWN_IO;
         starve_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         io_ack_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         starve_q    <= starve_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         io_ack_q    <= io_ack_d;
      end
   end

   assign bus.memEn    = mem_en_q;
   assign bus.memWe    = mem_we_q;
   assign bus.memAddr  = mem_addr_q;
   assign bus.memWdata = mem_wdata_q;
   assign bus.cpuAck   = cpu_ack_q;
   assign bus.ioAck    = io_ack_q;

   logic              cpu_rvalid, io_rvalid;
   logic [DATA_W-1:0] cpu_rdata, io_rdata;

   mem_rd_return_pipe #(
      .DATA_W      (DATA_W),
      .MEM_LATENCY (MEM_LATENCY)
   ) u_rd_pipe (
      .clock        (clock),
      .reset        (reset),
      .issue_i      (mem_en_q & ~mem_we_q),
      .owner_i      ((state_q == IO_ACC) ? OWN_IO : OWN_CPU),
      .mem_rdata_i  (bus.memRdata),
      .cpu_rvalid_o (cpu_rvalid),
      .cpu_rdata_o  (cpu_rdata),
      .io_rvalid_o  (io_rvalid),
      .io_rdata_o   (io_rdata)
   );

   assign bus.cpuRvalid = cpu_rvalid;
   assign bus.cpuRdata  = cpu_rdata;
   assign bus.ioRvalid  = io_rvalid;
   assign bus.ioRdata   = io_rdata;

`ifdef MEM_ARB_STATS_EN
   logic              cpu_grant, io_grant, conflict;
   logic [STAT_W-1:0] cpu_gcnt_q, io_gcnt_q, conflict_q;

   assign cpu_grant = (state_q == IDLE) && (state_d == CPU_ACC);
   assign io_grant  = (state_q == IDLE) && (state_d == IO_ACC);
   assign conflict  = (state_q == IDLE) && both_req;

   // Saturating grant/conflict statistics.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cpu_gcnt_q <= '0;
         io_gcnt_q  <= '0;
         conflict_q <= '0;
      end else begin
         if (cpu_grant && (cpu_gcnt_q != '1)) cpu_gcnt_q <= cpu_gcnt_q + STAT_W'(1);
         if (io_grant  && (io_gcnt_q  != '1)) io_gcnt_q  <= io_gcnt_q  + STAT_W'(1);
         if (conflict  && (conflict_q != '1)) conflict_q <= conflict_q + STAT_W'(1);
      end
   end

   assign cpuGrantCnt = cpu_gcnt_q;
   assign ioGrantCnt  = io_gcnt_q;
   assign conflictCnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (CPU priority, round-robin,
// 3-cycle memory latency) sharing clock and reset, each with a memory model
// that presents read data only during the cycle the latency predicts.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   typedef struct packed {
      logic        cpu_ack;
      logic        io_ack;
      logic        mem_en;
      logic        mem_we;
      logic [15:0] mem_addr;
      logic [15:0] mem_wdata;
      logic        cpu_rvalid;
      logic [15:0] cpu_rdata;
      logic        io_rvalid;
      logic [15:0] io_rdata;
   } out_t;

   typedef struct packed {
      logic        c_req;
      logic        c_we;
      logic [15:0] c_addr;
      logic [15:0] c_wdata;
      logic        i_req;
      logic        i_we;
      logic [15:0] i_addr;
      logic [15:0] i_wdata;
      logic [15:0] rd;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] rd_val;
   int          checks = 0;
   int          errors = 0;
   int          acc_cnt = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if_pri ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if_rr  ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if_lat ();

`ifdef MEM_ARB_STATS_EN
   logic [15:0] pri_cg, pri_ig, pri_cf, rr_cg, rr_ig, rr_cf, lat_cg, lat_ig, lat_cf;
`endif

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1), .CPU_PRIORITY(1), .STARVE_LIMIT(4))
   u_pri (.clock(clk), .reset(rst_n), .bus(if_pri)
`ifdef MEM_ARB_STATS_EN
          , .cpuGrantCnt(pri_cg), .ioGrantCnt(pri_ig), .conflictCnt(pri_cf)
`endif
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1), .CPU_PRIORITY(0), .STARVE_LIMIT(4))
   u_rr (.clock(clk), .reset(rst_n), .bus(if_rr)
`ifdef MEM_ARB_STATS_EN
         , .cpuGrantCnt(rr_cg), .ioGrantCnt(rr_ig), .conflictCnt(rr_cf)
`endif
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3), .CPU_PRIORITY(1), .STARVE_LIMIT(4))
   u_lat (.clock(clk), .reset(rst_n), .bus(if_lat)
`ifdef MEM_ARB_STATS_EN
          , .cpuGrantCnt(lat_cg), .ioGrantCnt(lat_ig), .conflictCnt(lat_cf)
`endif
   );

   // Memory models: read data appears MEM_LATENCY cycles after memEn, else 0.
   logic       pri_rd_q, rr_rd_q;
   logic [2:0] lat_rd_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pri_rd_q <= 1'b0;
         rr_rd_q  <= 1'b0;
         lat_rd_q <= 3'b000;
      end else begin
         pri_rd_q <= if_pri.memEn & ~if_pri.memWe;
         rr_rd_q  <= if_rr.memEn & ~if_rr.memWe;
         lat_rd_q <= {lat_rd_q[1:0], if_lat.memEn & ~if_lat.memWe};
      end
   end
   assign if_pri.memRdata = pri_rd_q    ? rd_val : 16'h0000;
   assign if_rr.memRdata  = rr_rd_q     ? rd_val : 16'h0000;
   assign if_lat.memRdata = lat_rd_q[2] ? rd_val : 16'h0000;

   always @(negedge clk) if (if_pri.memEn) acc_cnt <= acc_cnt + 1;

   function automatic out_t o(input logic ca, input logic ia, input logic en, input logic we,
                              input logic [15:0] ad, input logic [15:0] wd,
                              input logic crv, input logic [15:0] crd,
                              input logic irv, input logic [15:0] ird);
      return '{cpu_ack: ca, io_ack: ia, mem_en: en, mem_we: we, mem_addr: ad, mem_wdata: wd,
               cpu_rvalid: crv, cpu_rdata: crd, io_rvalid: irv, io_rdata: ird};
   endfunction

   function automatic vec_t v(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                              input logic ir, input logic iw, input logic [15:0] ia, input logic [15:0] id,
                              input logic [15:0] rd, input out_t e);
      return '{c_req: cr, c_we: cw, c_addr: ca, c_wdata: cd, i_req: ir, i_we: iw,
               i_addr: ia, i_wdata: id, rd: rd, exp: e};
   endfunction

   function automatic out_t snap_pri();
      return o(if_pri.cpuAck, if_pri.ioAck, if_pri.memEn, if_pri.memWe, if_pri.memAddr, if_pri.memWdata,
               if_pri.cpuRvalid, if_pri.cpuRdata, if_pri.ioRvalid, if_pri.ioRdata);
   endfunction

   function automatic out_t snap_rr();
      return o(if_rr.cpuAck, if_rr.ioAck, if_rr.memEn, if_rr.memWe, if_rr.memAddr, if_rr.memWdata,
               if_rr.cpuRvalid, if_rr.cpuRdata, if_rr.ioRvalid, if_rr.ioRdata);
   endfunction

   function automatic out_t snap_lat();
      return o(if_lat.cpuAck, if_lat.ioAck, if_lat.memEn, if_lat.memWe, if_lat.memAddr, if_lat.memWdata,
               if_lat.cpuRvalid, if_lat.cpuRdata, if_lat.ioRvalid, if_lat.ioRdata);
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_reqs();
      if_pri.cpuReq = 1'b0; if_pri.ioReq = 1'b0;
      if_rr.cpuReq  = 1'b0; if_rr.ioReq  = 1'b0;
      if_lat.cpuReq = 1'b0; if_lat.ioReq = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [10];
   logic seen;

   initial begin
      vecs[0] = v(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,
                  o(1, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000));
      vecs[1] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,
                  o(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 16'h0000));
      vecs[2] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,
                  o(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0, 16'h0000));
      vecs[3] = v(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'h1234, 16'hBEEF,
                  o(0, 1, 1, 1, 16'h0200, 16'h1234, 0, 16'hBEEF, 0, 16'h0000));
      vecs[4] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,
                  o(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0, 16'h0000));
      vecs[5] = v(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0300, 16'h0000, 16'hCAFE,
                  o(0, 1, 1, 0, 16'h0300, 16'h0000, 0, 16'hBEEF, 0, 16'h0000));
      vecs[6] = v(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hCAFE,
                  o(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1, 16'hCAFE));
      vecs[7] = v(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hCAFE,
                  o(1, 0, 1, 0, 16'h0040, 16'h0000, 0, 16'hBEEF, 0, 16'hCAFE));
      vecs[8] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1357,
                  o(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h1357, 0, 16'hCAFE));
      vecs[9] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1357,
                  o(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h1357, 0, 16'hCAFE));

      // Reset with unknown requests.
      rst_n  = 1'b0;
      rd_val = 16'h0000;
      if_pri.cpuReq = 1'bx; if_pri.ioReq = 1'bx;
      if_rr.cpuReq  = 1'bx; if_rr.ioReq  = 1'bx;
      if_lat.cpuReq = 1'bx; if_lat.ioReq = 1'bx;
      if_pri.cpuWe = 0; if_pri.cpuAddr = 0; if_pri.cpuWdata = 0;
      if_pri.ioWe  = 0; if_pri.ioAddr  = 0; if_pri.ioWdata  = 0;
      if_rr.cpuWe  = 0; if_rr.cpuAddr  = 0; if_rr.cpuWdata  = 0;
      if_rr.ioWe   = 0; if_rr.ioAddr   = 0; if_rr.ioWdata   = 0;
      if_lat.cpuWe = 0; if_lat.cpuAddr = 0; if_lat.cpuWdata = 0;
      if_lat.ioWe  = 0; if_lat.ioAddr  = 0; if_lat.ioWdata  = 0;
      step();
      step();
      chk("reset_pri", {2'b00, snap_pri()}, 72'(0));
      chk("reset_rr",  {2'b00, snap_rr()},  72'(0));
      chk("reset_lat", {2'b00, snap_lat()}, 72'(0));
      idle_reqs();
      rst_n = 1'b1;

      // Directed single-requester vectors on the priority instance.
      for (int i = 0; i < 10; i++) begin
         if_pri.cpuReq = vecs[i].c_req; if_pri.cpuWe = vecs[i].c_we;
         if_pri.cpuAddr = vecs[i].c_addr; if_pri.cpuWdata = vecs[i].c_wdata;
         if_pri.ioReq = vecs[i].i_req; if_pri.ioWe = vecs[i].i_we;
         if_pri.ioAddr = vecs[i].i_addr; if_pri.ioWdata = vecs[i].i_wdata;
         rd_val = vecs[i].rd;
         step();
         chk($sformatf("vec%0d", i), {2'b00, snap_pri()}, {2'b00, vecs[i].exp});
      end

      // Continuous contention, CPU priority with starvation guard at 4.
      if_pri.cpuReq = 1'b1; if_pri.cpuWe = 1'b0; if_pri.cpuAddr = 16'h0100;
      if_pri.ioReq  = 1'b1; if_pri.ioWe  = 1'b0; if_pri.ioAddr  = 16'h0900;
      for (int g = 0; g < 10; g++) begin
         step();
         chk($sformatf("pri_grant%0d", g), 72'({if_pri.cpuAck, if_pri.ioAck}),
             72'(((g % 5) == 4) ? 2'b01 : 2'b10));
         step();
         chk($sformatf("pri_gap%0d", g), 72'(if_pri.memEn), 72'(1'b0));
      end
      idle_reqs();
      step();
      chk("acc_cycles", 72'(acc_cnt), 72'(14));
`ifdef MEM_ARB_STATS_EN
      chk("conflictCnt", 72'(pri_cf), 72'(16'd10));
      chk("grant_sum", 72'(32'(pri_cg) + 32'(pri_ig)), 72'(acc_cnt));
      chk("cpuGrantCnt", 72'(pri_cg), 72'(16'd10));
`endif

      // Continuous contention, round-robin: CPU first, then strict alternation.
      if_rr.cpuReq = 1'b1; if_rr.ioReq = 1'b1;
      for (int g = 0; g < 6; g++) begin
         step();
         chk($sformatf("rr_grant%0d", g), 72'({if_rr.cpuAck, if_rr.ioAck}),
             72'(((g % 2) == 1) ? 2'b01 : 2'b10));
         step();
      end
      idle_reqs();
      step();

      // Three-cycle latency read.
      rd_val = 16'hA5A5;
      if_lat.cpuReq = 1'b1; if_lat.cpuAddr = 16'h0050;
      step();
      chk("lat_ack", 72'({if_lat.cpuAck, if_lat.memEn, if_lat.memAddr}), 72'({2'b11, 16'h0050}));
      if_lat.cpuReq = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("lat_rv%0d", k), 72'({if_lat.cpuRvalid, if_lat.cpuRdata}),
             (k == 3) ? 72'({1'b1, 16'hA5A5}) : 72'({1'b0, 16'h0000}));
      end

      // IO return coinciding with a CPU ack.
      if_lat.ioReq = 1'b1; if_lat.ioAddr = 16'h0060;
      step();
      chk("lat_io_ack", 72'(if_lat.ioAck), 72'(1'b1));
      if_lat.ioReq = 1'b0;
      step();
      step();
      if_lat.cpuReq = 1'b1; if_lat.cpuAddr = 16'h0070;
      step();
      chk("coincide", 72'({if_lat.cpuAck, if_lat.ioRvalid, if_lat.ioRdata}), 72'({2'b11, 16'hA5A5}));
      if_lat.cpuReq = 1'b0;
      for (int k = 0; k < 4; k++) step();

      // Reset with a read in flight.
      if_lat.cpuReq = 1'b1; if_lat.cpuAddr = 16'h0080;
      step();
      chk("inflight_ack", 72'(if_lat.cpuAck), 72'(1'b1));
      if_lat.cpuReq = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("async_reset", {2'b00, snap_lat()}, 72'(0));
      step();
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         seen = seen | if_lat.cpuRvalid | if_lat.ioRvalid;
      end
      chk("no_rvalid_after_reset", 72'(seen), 72'(1'b0));
      chk("rdata_cleared", 72'(if_lat.cpuRdata), 72'(16'h0000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
